// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera configuration sequencer.
// Holds the FSM state enum, table word encodings and the delay-length helper.
package cam_cfg_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PWRUP,
      ST_FETCH,
      ST_LOAD,
      ST_REQ,
      ST_WAIT_ACK,
      ST_DELAY,
      ST_GAP,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [31:0] CFG_END     = 32'hFFFF_FFFF;
   localparam logic [7:0]  CFG_DLY_TAG = 8'hFE;
   localparam int          DLY_HI      = 15;
   localparam int          DLY_LO      = 0;

   // Delay length in cycles: a zero count still waits one cycle, and the
   // product saturates instead of wrapping when it overflows 32 bits.
   function automatic logic [31:0] dly_cycles(
      input logic [15:0] cnt,
      input logic [31:0] unit
   );
      logic [47:0] p;
      p = {32'b0, cnt} * {16'b0, unit};
      if (p == '0)
         return 32'd1;
      if (|p[47:32])
         return 32'hFFFF_FFFF;
      return p[31:0];
   endfunction

endpackage

// File: rtl/cfg_timer.sv
// Loadable 32-bit down-counter shared by every wait state of the sequencer.
// Ports: clk_100/rst_100, load + load_val to (re)arm, expired on the last cycle.
module cfg_timer (
   input  logic        clk_100,
   input  logic        rst_100,
   input  logic        load,
   input  logic [31:0] load_val,
   output logic        expired
);

   logic [31:0] cnt_q;

   always_ff @(posedge clk_100) begin
      if (rst_100)
         cnt_q <= '0;
      else if (load)
         cnt_q <= load_val;
      else if (cnt_q != '0)
         cnt_q <= cnt_q - 32'd1;
   end

   // Loading N makes the owning state last exactly N cycles.
   assign expired = (cnt_q <= 32'd1);

endmodule

// File: rtl/cam_cfg_seq.sv
// Camera register-configuration sequencer: walks an external table of I2C
// words, handing each to the byte sender via i2c_req/i2c_ack.
// Ports: clk_100/rst_100, start, cfg_addr/cfg_rdata table port,
// cfg_data/i2c_req/i2c_ack sender handshake, busy/done/err status, reg_idx.
module cam_cfg_seq
   import cam_cfg_pkg::*;
#(
   parameter int N_REGS         = 256,
   parameter int PWRUP_CYCLES   = 2_000_000,
   parameter int GAP_CYCLES     = 10_000,
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int DLY_UNIT       = 1000,
   localparam int IW            = $clog2(N_REGS)
) (
   input  logic          clk_100,
   input  logic          rst_100,
   input  logic          start,
   output logic [IW-1:0] cfg_addr,
   input  logic [31:0]   cfg_rdata,
   output logic [31:0]   cfg_data,
   output logic          i2c_req,
   input  logic          i2c_ack,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [IW-1:0] reg_idx
);

   localparam logic [IW-1:0] LAST = IW'(N_REGS - 1);

   state_t        state_q;
   state_t        state_d;
   logic [IW-1:0] idx_q;
   logic [31:0]   data_q;
   logic          tmr_ld;
   logic [31:0]   tmr_val;
   logic          tmr_exp;
   logic          idx_clr;
   logic          idx_inc;
   logic          data_ld;

   cfg_timer u_timer (
      .clk_100  (clk_100),
      .rst_100  (rst_100),
      .load     (tmr_ld),
      .load_val (tmr_val),
      .expired  (tmr_exp)
   );

   always_ff @(posedge clk_100) begin
      if (rst_100) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (idx_clr)
            idx_q <= '0;
         else if (idx_inc)
            idx_q <= idx_q + 1'b1;
         if (data_ld)
            data_q <= cfg_rdata;
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_ld  = 1'b0;
      tmr_val = '0;
      idx_clr = 1'b0;
      idx_inc = 1'b0;
      data_ld = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d = ST_PWRUP;
               idx_clr = 1'b1;
               tmr_ld  = 1'b1;
               tmr_val = 32'(PWRUP_CYCLES);
            end
         end
         ST_PWRUP: begin
            if (tmr_exp)
               state_d = ST_FETCH;
         end
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            if (cfg_rdata == CFG_END) begin
               state_d = ST_DONE;
            end else if (cfg_rdata[31:24] == CFG_DLY_TAG) begin
               state_d = ST_DELAY;
               tmr_ld  = 1'b1;
               tmr_val = dly_cycles(cfg_rdata[DLY_HI:DLY_LO],
                                    32'(DLY_UNIT));
            end else begin
               state_d = ST_REQ;
               data_ld = 1'b1;
            end
         end
         ST_REQ: begin
            state_d = ST_WAIT_ACK;
            tmr_ld  = 1'b1;
            tmr_val = 32'(TIMEOUT_CYCLES);
         end
         ST_WAIT_ACK: begin
            // An ack on the final timeout cycle still counts.
            if (i2c_ack) begin
               state_d = ST_GAP;
               tmr_ld  = 1'b1;
               tmr_val = 32'(GAP_CYCLES);
            end else if (tmr_exp) begin
               state_d = ST_ERR;
            end
         end
         ST_DELAY, ST_GAP: begin
            if (tmr_exp) begin
               if (idx_q == LAST) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_FETCH;
                  idx_inc = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cfg_addr = idx_q;
   assign reg_idx  = idx_q;
   assign cfg_data = data_q;
   assign i2c_req  = (state_q == ST_REQ);
   assign done     = (state_q == ST_DONE);
   assign err      = (state_q == ST_ERR);
   assign busy     = !(state_q == ST_IDLE ||
                       state_q == ST_DONE ||
                       state_q == ST_ERR);

endmodule

// File: tb/tb_cam_cfg_seq.sv
// Directed bench for cam_cfg_seq with a registered table model and an
// acking sender model (ack 20 cycles after each request).
module tb_cam_cfg_seq;

   logic        clk_100;
   logic        rst_100;
   logic        start;
   logic [1:0]  cfg_addr;
   logic [31:0] cfg_rdata;
   logic [31:0] cfg_data;
   logic        i2c_req;
   logic        i2c_ack;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  reg_idx;

   cam_cfg_seq #(
      .N_REGS         (4),
      .PWRUP_CYCLES   (10),
      .GAP_CYCLES     (5),
      .TIMEOUT_CYCLES (200),
      .DLY_UNIT       (4)
   ) dut (
      .clk_100   (clk_100),
      .rst_100   (rst_100),
      .start     (start),
      .cfg_addr  (cfg_addr),
      .cfg_rdata (cfg_rdata),
      .cfg_data  (cfg_data),
      .i2c_req   (i2c_req),
      .i2c_ack   (i2c_ack),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .reg_idx   (reg_idx)
   );

   initial clk_100 = 1'b0;
   always #5 clk_100 = ~clk_100;

   logic [31:0] tbl [4];

   always @(posedge clk_100)
      cfg_rdata <= tbl[cfg_addr];

   int          n_chk;
   int          n_pass;
   int          rel;
   int          req_cyc[$];
   logic [31:0] req_dat[$];
   int          done_cyc;
   int          err_cyc;
   int          busy_rises;
   int          ack_at;
   bit          ack_en;
   logic        prev_busy;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic step();
      @(negedge clk_100);
      rel++;
      i2c_ack = 1'b0;
      if (i2c_req) begin
         req_cyc.push_back(rel);
         req_dat.push_back(cfg_data);
         ack_at = rel + 20;
      end
      if (ack_en && rel == ack_at)
         i2c_ack = 1'b1;
      if (done && done_cyc < 0)
         done_cyc = rel;
      if (err && err_cyc < 0)
         err_cyc = rel;
      if (busy && !prev_busy)
         busy_rises++;
      prev_busy = busy;
   endtask

   task automatic start_run(input bit hold);
      req_cyc.delete();
      req_dat.delete();
      done_cyc   = -1;
      err_cyc    = -1;
      busy_rises = 0;
      ack_at     = -1;
      prev_busy  = busy;
      rel        = 0;
      start      = 1'b1;
      step();
      if (!hold)
         start = 1'b0;
   endtask

   task automatic run_until_end(input string tag);
      for (int i = 0; i < 2000 && !(done || err); i++)
         step();
      chk(tag, 64'(done | err), 64'd1);
   endtask

   task automatic do_reset();
      rst_100 = 1'b1;
      step();
      step();
      rst_100 = 1'b0;
   endtask

   task automatic load_normal();
      tbl[0] = 32'h7800_1234;
      tbl[1] = 32'h7800_5678;
      tbl[2] = 32'h7800_9ABC;
      tbl[3] = 32'h7800_DEF0;
   endtask

   initial begin
      n_chk   = 0;
      n_pass  = 0;
      rel     = 0;
      ack_en  = 1'b1;
      ack_at  = -1;
      start   = 1'b0;
      i2c_ack = 1'b0;
      rst_100 = 1'b1;
      load_normal();
      done_cyc = -1;
      err_cyc  = -1;
      prev_busy = 1'b0;
      repeat (3) @(negedge clk_100);
      chk("rst_outs",
          64'({busy, done, err, i2c_req, cfg_addr, reg_idx, cfg_data}),
          64'd0);
      rst_100 = 1'b0;
      step();

      // Normal four-entry sequence.
      start_run(1'b0);
      run_until_end("norm_end");
      chk("norm_nreq", 64'(req_cyc.size()), 64'd4);
      if (req_cyc.size() == 4) begin
         chk("norm_req0_t", 64'(req_cyc[0]), 64'd13);
         chk("norm_req1_t", 64'(req_cyc[1]), 64'd41);
         chk("norm_req3_t", 64'(req_cyc[3]), 64'd97);
         chk("norm_d0", 64'(req_dat[0]), 64'h7800_1234);
         chk("norm_d1", 64'(req_dat[1]), 64'h7800_5678);
         chk("norm_d2", 64'(req_dat[2]), 64'h7800_9ABC);
         chk("norm_d3", 64'(req_dat[3]), 64'h7800_DEF0);
      end
      chk("norm_done_t", 64'(done_cyc), 64'd123);
      step();
      chk("norm_busy", 64'({busy, done}), 64'b01);

      // End marker after one entry.
      tbl[0] = 32'h7800_0001;
      tbl[1] = 32'hFFFF_FFFF;
      tbl[2] = 32'h7800_0AAA;
      tbl[3] = 32'h7800_0BBB;
      start_run(1'b0);
      run_until_end("end_end");
      repeat (5) step();
      chk("end_nreq", 64'(req_cyc.size()), 64'd1);
      chk("end_done_t", 64'(done_cyc), 64'd41);
      chk("end_done", 64'({done, err, busy}), 64'b100);

      // In-table delay command of 3 * 4 cycles.
      tbl[0] = 32'hFE00_0003;
      tbl[1] = 32'h7800_0002;
      tbl[2] = 32'hFFFF_FFFF;
      tbl[3] = 32'h7800_0CCC;
      start_run(1'b0);
      run_until_end("dly_end");
      chk("dly_nreq", 64'(req_cyc.size()), 64'd1);
      if (req_cyc.size() == 1) begin
         chk("dly_req_t", 64'(req_cyc[0]), 64'd27);
         chk("dly_d", 64'(req_dat[0]), 64'h7800_0002);
      end
      chk("dly_done_t", 64'(done_cyc), 64'd55);

      // Ack timeout, then restart clears err.
      load_normal();
      ack_en = 1'b0;
      start_run(1'b0);
      run_until_end("tmo_end");
      repeat (10) step();
      chk("tmo_err_t", 64'(err_cyc), 64'd214);
      chk("tmo_nreq", 64'(req_cyc.size()), 64'd1);
      chk("tmo_stat", 64'({err, busy, i2c_req, done}), 64'b1000);
      ack_en = 1'b1;
      start_run(1'b0);
      chk("rerun_err", 64'({err, busy}), 64'b01);
      run_until_end("rerun_end");
      chk("rerun_nreq", 64'(req_cyc.size()), 64'd4);
      chk("rerun_done", 64'({done, err}), 64'b10);

      // Held start: no re-entry into PWRUP before DONE.
      start_run(1'b1);
      run_until_end("hold_end");
      chk("hold_nreq", 64'(req_cyc.size()), 64'd4);
      chk("hold_rises", 64'(busy_rises), 64'd1);
      chk("hold_done_t", 64'(done_cyc), 64'd123);
      step();
      chk("hold_restart", 64'({busy, done}), 64'b10);
      start = 1'b0;
      do_reset();

      // Reset while waiting for an ack.
      start_run(1'b0);
      while (rel < 18)
         step();
      chk("rst_wait_busy", 64'({busy, i2c_req}), 64'b10);
      rst_100 = 1'b1;
      ack_en  = 1'b0;
      step();
      chk("rst_mid_outs",
          64'({busy, done, err, i2c_req, cfg_addr, reg_idx, cfg_data}),
          64'd0);
      rst_100 = 1'b0;
      repeat (40) step();
      chk("rst_no_reissue", 64'(req_cyc.size()), 64'd1);
      chk("rst_idle", 64'({busy, done, err}), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
